multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; even, >= 8.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port Clock  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  in  1  request; accepted only when Busy=0.
REQ-006 SHALL have port FunSel  in  5  [4]=width select (1 full, 0 half), [3:0]=operation.
REQ-007 SHALL have ports A, B  in  WIDTH  operands.
REQ-008 SHALL have port ShAmt  in  SHW  shift/rotate count, used by ops 1011-1111 only.
REQ-009 SHALL have port WF  in  1  flag write enable for this operation.
REQ-010 SHALL have port Busy  out  1  high from the cycle after acceptance until the Done cycle inclusive.
REQ-011 SHALL have port Done  out  1  one-cycle pulse; ALUOut valid from this cycle.
REQ-012 SHALL have port ALUOut  out  WIDTH  registered result; held until the next Done.
REQ-013 SHALL have port FlagsOut  out  4  registered {Z,C,N,O} at bits [3:0] = Z,C,N,O respectively ([3]=Z, [0]=O).

Function
REQ-014 SHALL capture FunSel, A, B, ShAmt, WF on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-015 SHALL implement FSM IDLE -> EXEC -> DONE for ops 0000-1010; IDLE -> SHIFT -> DONE for 1011-1111; DONE -> IDLE unconditionally.
REQ-016 Ops SHALL be: 0000 A, 0001 B, 0010 ~A, 0011 ~B, 0100 A+B, 0101 A+B+C, 0110 A-B, 0111 A&B, 1000 A|B, 1001 A^B, 1010 ~(A&B), 1011 LSL, 1100 LSR, 1101 ASR, 1110 CSL (rotate left through C), 1111 CSR (rotate right through C).
REQ-017 Non-shift ops SHALL assert Done exactly 2 cycles after the accepting edge.
REQ-018 Shift ops SHALL shift one bit per SHIFT cycle, ShAmt cycles, then Done; ShAmt=0 SHALL spend one SHIFT cycle with operand unchanged and C untouched.
REQ-019 FunSel[4]=0 SHALL operate on the low WIDTH/2 bits; result sign-extended from bit WIDTH/2-1; C, N, O from the half-width result.
REQ-020 Add C SHALL be carry-out; subtract C SHALL be carry-out of A+~B+1; shifts C SHALL be last bit shifted out; CSL/CSR rotate through C iteratively using the running C.
REQ-021 O SHALL be signed overflow for 0100, 0101, 0110.
REQ-022 With captured WF=1 at Done: Z updated for all ops; C for 0100-0110, 1011, 1100, 1110, 1111; N for all except 1101; O for 0100-0110; others held.
REQ-023 With captured WF=0, FlagsOut SHALL be unchanged (intermediate rotate C SHALL be internal).
REQ-024 Start while Busy=1 SHALL be ignored; Start in the DONE cycle SHALL be ignored.
REQ-025 A+B+C SHALL use FlagsOut C as sampled at acceptance.

Reset
REQ-026 Reset=1 SHALL asynchronously force IDLE, Busy=0, Done=0, ALUOut=0, FlagsOut=0000.
REQ-027 Reset mid-operation SHALL abort with no Done pulse and no flag update.

Structure
REQ-028 Package alu_pkg SHALL hold FunSel op constants, flag bit indices, and the FSM state enum.
REQ-029 One sub-module alu_shift_step SHALL perform a single-bit shift/rotate step (data, carry in -> data, carry out), combinational, parametrised by WIDTH.

Verification
REQ-030 Full-width ADD A=FFFFFFFF, B=00000001, WF=1 -> Done at +2, ALUOut=00000000, Z=1, C=1, N=0, O=0.
REQ-031 Half-width SUB (FunSel=00110) A=00008000, B=00000001 -> ALUOut=00007FFF, O=1, N=0, C=1.
REQ-032 LSL ShAmt=4, A=F0000001, full -> Done at +ShAmt+1=5 cycles, ALUOut=00000010, C=1; Busy high 5 cycles.
REQ-033 CSR ShAmt=1, C=1, A=00000002, full -> ALUOut=80000001, C=0.
REQ-034 Start re-asserted with different A while Busy -> ignored, result from first operands; WF=0 op -> FlagsOut unchanged.
REQ-035 Reset asserted mid LSL (ShAmt=10, cycle 3) -> immediate ALUOut=0, FlagsOut=0, no Done; next Start accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - FunSel[3:0] operation codes
//   - FlagsOut bit positions ({Z,C,N,O} at [3:0])
//   - controller state enumeration
package alu_pkg;

    localparam logic [3:0] OpPassA = 4'b0000;
    localparam logic [3:0] OpPassB = 4'b0001;
    localparam logic [3:0] OpNotA  = 4'b0010;
    localparam logic [3:0] OpNotB  = 4'b0011;
    localparam logic [3:0] OpAdd   = 4'b0100;
    localparam logic [3:0] OpAdc   = 4'b0101;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpAnd   = 4'b0111;
    localparam logic [3:0] OpOr    = 4'b1000;
    localparam logic [3:0] OpXor   = 4'b1001;
    localparam logic [3:0] OpNand  = 4'b1010;
    localparam logic [3:0] OpLsl   = 4'b1011;
    localparam logic [3:0] OpLsr   = 4'b1100;
    localparam logic [3:0] OpAsr   = 4'b1101;
    localparam logic [3:0] OpCsl   = 4'b1110;
    localparam logic [3:0] OpCsr   = 4'b1111;

    localparam int unsigned FlagZ = 3;
    localparam int unsigned FlagC = 2;
    localparam int unsigned FlagN = 1;
    localparam int unsigned FlagO = 0;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StShift,
        StDone
    } alu_state_e;

    // Shift/rotate ops occupy the top of the opcode space.
    function automatic logic is_shift_op(input logic [3:0] op);
        return op >= OpLsl;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: one single-bit shift/rotate step, purely combinational.
//   op_i    : operation code (only LSL/LSR/ASR/CSL/CSR act; others pass through)
//   data_i  : value to shift
//   carry_i : running carry, shifted in by CSL/CSR
//   data_o  : shifted value
//   carry_o : bit shifted out (carry_i for non-shift codes)
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o
);

    always_comb begin
        data_o  = data_i;
        carry_o = carry_i;
        case (op_i)
            OpLsl: begin
                data_o  = {data_i[WIDTH-2:0], 1'b0};
                carry_o = data_i[WIDTH-1];
            end
            OpLsr: begin
                data_o  = {1'b0, data_i[WIDTH-1:1]};
                carry_o = data_i[0];
            end
            OpAsr: begin
                data_o  = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
                carry_o = data_i[0];
            end
            OpCsl: begin
                data_o  = {data_i[WIDTH-2:0], carry_i};
                carry_o = data_i[WIDTH-1];
            end
            OpCsr: begin
                data_o  = {carry_i, data_i[WIDTH-1:1]};
                carry_o = data_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: ALU with a 2-cycle logic/arithmetic path and an iterative
// one-bit-per-cycle shifter.
//   Clock    : rising-edge clock
//   Reset    : asynchronous active-high reset
//   Start    : request, accepted only in IDLE
//   FunSel   : [4] 1=full width, 0=half width; [3:0] operation
//   A, B     : operands
//   ShAmt    : shift/rotate count
//   WF       : flag write enable for this operation
//   Busy     : high from the cycle after acceptance through the Done cycle
//   Done     : one-cycle completion pulse
//   ALUOut   : registered result, held until the next Done
//   FlagsOut : registered {Z,C,N,O}
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       FunSel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   ShAmt,
    input  logic             WF,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut
);

    localparam int HALF = WIDTH / 2;

    alu_state_e state_q, state_d;

    logic             full_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;      // also the shift working register
    logic [WIDTH-1:0] b_q;
    logic [SHW-1:0]   cnt_q;
    logic             wf_q;
    logic             carry_q;  // C at acceptance, then the running rotate carry
    logic [WIDTH-1:0] alu_out_q;
    logic [3:0]       flags_q;

    logic             accept;
    logic             finish;
    logic [WIDTH-1:0] step_f_data;
    logic [HALF-1:0]  step_h_data;
    logic             step_f_carry, step_h_carry;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;
    logic [WIDTH-1:0] b_eff;
    logic             c_in;
    logic [WIDTH:0]   sum_f;
    logic [HALF:0]    sum_h;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] result;
    logic             carry_res;
    logic             ovf;
    logic             msb_a, msb_b;
    logic             is_arith, updates_c;
    logic [3:0]       flags_d;

    assign accept = Start && (state_q == StIdle);
    // Result and flags are written on the edge that enters DONE.
    assign finish = (state_q == StExec) ||
                    ((state_q == StShift) && (cnt_q <= SHW'(1)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (Start) state_d = is_shift_op(FunSel[3:0]) ? StShift : StExec;
            StExec:  state_d = StDone;
            StShift: if (cnt_q <= SHW'(1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign Busy = (state_q != StIdle);
    assign Done = (state_q == StDone);

    alu_shift_step #(.WIDTH(WIDTH)) u_step_full (
        .op_i    (op_q),
        .data_i  (a_q),
        .carry_i (carry_q),
        .data_o  (step_f_data),
        .carry_o (step_f_carry)
    );

    alu_shift_step #(.WIDTH(HALF)) u_step_half (
        .op_i    (op_q),
        .data_i  (a_q[HALF-1:0]),
        .carry_i (carry_q),
        .data_o  (step_h_data),
        .carry_o (step_h_carry)
    );

    assign step_data  = full_q ? step_f_data : {a_q[WIDTH-1:HALF], step_h_data};
    assign step_carry = full_q ? step_f_carry : step_h_carry;

    assign is_arith  = (op_q == OpAdd) || (op_q == OpAdc) || (op_q == OpSub);
    assign updates_c = is_arith || (op_q == OpLsl) || (op_q == OpLsr) ||
                       (op_q == OpCsl) || (op_q == OpCsr);

    // Subtract is A + ~B + 1.
    assign b_eff = (op_q == OpSub) ? ~b_q : b_q;
    assign c_in  = (op_q == OpSub) ? 1'b1 : ((op_q == OpAdc) ? carry_q : 1'b0);
    assign sum_f = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_in};
    assign sum_h = {1'b0, a_q[HALF-1:0]} + {1'b0, b_eff[HALF-1:0]} + {{HALF{1'b0}}, c_in};

    always_comb begin
        raw = a_q;
        case (op_q)
            OpPassA:              raw = a_q;
            OpPassB:              raw = b_q;
            OpNotA:               raw = ~a_q;
            OpNotB:               raw = ~b_q;
            OpAdd, OpAdc, OpSub:  raw = full_q ? sum_f[WIDTH-1:0]
                                               : {{HALF{1'b0}}, sum_h[HALF-1:0]};
            OpAnd:                raw = a_q & b_q;
            OpOr:                 raw = a_q | b_q;
            OpXor:                raw = a_q ^ b_q;
            OpNand:               raw = ~(a_q & b_q);
            default:              raw = (cnt_q == '0) ? a_q : step_data;
        endcase
    end

    assign result = full_q ? raw : {{HALF{raw[HALF-1]}}, raw[HALF-1:0]};

    always_comb begin
        carry_res = carry_q;
        if (is_arith) begin
            carry_res = full_q ? sum_f[WIDTH] : sum_h[HALF];
        end else if (cnt_q != '0) begin
            carry_res = step_carry;
        end
    end

    assign msb_a = full_q ? a_q[WIDTH-1] : a_q[HALF-1];
    assign msb_b = full_q ? b_eff[WIDTH-1] : b_eff[HALF-1];
    // result is sign-extended in half mode, so its top bit is the half-width sign.
    assign ovf   = (msb_a == msb_b) && (result[WIDTH-1] != msb_a);

    always_comb begin
        flags_d = flags_q;
        if (wf_q) begin
            flags_d[FlagZ] = (result == '0);
            if (updates_c)      flags_d[FlagC] = carry_res;
            if (op_q != OpAsr)  flags_d[FlagN] = result[WIDTH-1];
            if (is_arith)       flags_d[FlagO] = ovf;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            full_q    <= 1'b0;
            op_q      <= OpPassA;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            wf_q      <= 1'b0;
            carry_q   <= 1'b0;
            alu_out_q <= '0;
            flags_q   <= '0;
        end else begin
            if (accept) begin
                full_q  <= FunSel[4];
                op_q    <= FunSel[3:0];
                a_q     <= A;
                b_q     <= B;
                cnt_q   <= ShAmt;
                wf_q    <= WF;
                carry_q <= flags_q[FlagC];
            end
            if ((state_q == StShift) && (cnt_q != '0)) begin
                a_q     <= step_data;
                carry_q <= step_carry;
                cnt_q   <= cnt_q - SHW'(1);
            end
            if (finish) begin
                alu_out_q <= result;
                flags_q   <= flags_d;
            end
        end
    end

    assign ALUOut   = alu_out_q;
    assign FlagsOut = flags_q;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [4:0]  FunSel;
    logic [31:0] A, B;
    logic [4:0]  ShAmt;
    logic        WF;
    logic        Busy, Done;
    logic [31:0] ALUOut;
    logic [3:0]  FlagsOut;

    int checks = 0;
    int errors = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .FunSel   (FunSel),
        .A        (A),
        .B        (B),
        .ShAmt    (ShAmt),
        .WF       (WF),
        .Busy     (Busy),
        .Done     (Done),
        .ALUOut   (ALUOut),
        .FlagsOut (FlagsOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  fs;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        wf;
        logic [31:0] out;
        logic [3:0]  flags;   // {Z,C,N,O}
        int          lat;     // cycles from acceptance to Done, inclusive
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one op, scramble inputs after acceptance, measure latency and Busy.
    task automatic run_vec(input vec_t v, input string tag);
        int cnt;
        int busy_cnt;
        logic seen;
        @(negedge Clock);
        FunSel = v.fs; A = v.a; B = v.b; ShAmt = v.sh; WF = v.wf; Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0; A = ~v.a; B = ~v.b; ShAmt = 5'd31; WF = ~v.wf; FunSel = ~v.fs;
        cnt = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && cnt < 64) begin
            @(negedge Clock);
            cnt++;
            if (Busy) busy_cnt++;
            if (Done) seen = 1'b1;
        end
        check({tag, ".done"}, {31'b0, seen}, 32'd1);
        check({tag, ".lat"}, cnt, v.lat);
        check({tag, ".busy"}, busy_cnt, v.lat);
        check({tag, ".out"}, ALUOut, v.out);
        check({tag, ".flags"}, {28'b0, FlagsOut}, {28'b0, v.flags});
        @(negedge Clock);
        check({tag, ".idle"}, {30'b0, Busy, Done}, 32'd0);
    endtask

    initial begin
        int cnt;
        logic seen;

        vecs[0]  = '{5'b10100, 32'hFFFFFFFF, 32'h00000001, 5'd0, 1'b1, 32'h00000000, 4'b1100, 2};
        vecs[1]  = '{5'b10101, 32'h00000001, 32'h00000002, 5'd0, 1'b1, 32'h00000004, 4'b0000, 2};
        vecs[2]  = '{5'b00110, 32'h00008000, 32'h00000001, 5'd0, 1'b1, 32'h00007FFF, 4'b0101, 2};
        vecs[3]  = '{5'b10111, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b1, 32'hF000F000, 4'b0111, 2};
        vecs[4]  = '{5'b01001, 32'h12345678, 32'h0000FFFF, 5'd0, 1'b1, 32'hFFFFA987, 4'b0111, 2};
        vecs[5]  = '{5'b11011, 32'hF0000001, 32'h00000000, 5'd4, 1'b1, 32'h00000010, 4'b0101, 5};
        vecs[6]  = '{5'b11111, 32'h00000002, 32'h00000000, 5'd1, 1'b1, 32'h80000001, 4'b0011, 2};
        vecs[7]  = '{5'b11101, 32'h80000010, 32'h00000000, 5'd3, 1'b1, 32'hF0000002, 4'b0011, 4};
        vecs[8]  = '{5'b10110, 32'h00000005, 32'h00000003, 5'd0, 1'b1, 32'h00000002, 4'b0100, 2};
        vecs[9]  = '{5'b11100, 32'h00000000, 32'h00000000, 5'd0, 1'b1, 32'h00000000, 4'b1100, 2};
        vecs[10] = '{5'b01110, 32'h0000C001, 32'h00000000, 5'd2, 1'b1, 32'h00000007, 4'b0100, 3};
        vecs[11] = '{5'b01010, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 32'hFFFFFFFF, 4'b0100, 2};
        vecs[12] = '{5'b10001, 32'h12345678, 32'h00000000, 5'd0, 1'b1, 32'h00000000, 4'b1100, 2};
        vecs[13] = '{5'b00010, 32'h0000FF00, 32'h00000000, 5'd0, 1'b1, 32'h000000FF, 4'b0100, 2};
        vecs[14] = '{5'b00100, 32'h00007FFF, 32'h00000001, 5'd0, 1'b1, 32'hFFFF8000, 4'b0011, 2};
        vecs[15] = '{5'b11000, 32'h00000000, 32'h00000000, 5'd0, 1'b1, 32'h00000000, 4'b1001, 2};
        vecs[16] = '{5'b00101, 32'h0000FFFF, 32'h00000001, 5'd0, 1'b1, 32'h00000000, 4'b1100, 2};

        Reset = 1'b1; Start = 1'b0; FunSel = '0; A = '0; B = '0; ShAmt = '0; WF = 1'b0;
        #12;
        check("reset.out", ALUOut, 32'd0);
        check("reset.flags", {28'b0, FlagsOut}, 32'd0);
        check("reset.ctl", {30'b0, Busy, Done}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Start held through Busy and the Done cycle with other operands: ignored.
        @(negedge Clock);
        FunSel = 5'b10100; A = 32'd1; B = 32'd2; WF = 1'b0; Start = 1'b1;
        @(posedge Clock);
        #1;
        A = 32'd100; B = 32'd200; WF = 1'b1;
        cnt = 0; seen = 1'b0;
        while (!seen && cnt < 64) begin
            @(negedge Clock);
            cnt++;
            if (Done) seen = 1'b1;
        end
        check("hold.lat", cnt, 2);
        check("hold.out", ALUOut, 32'd3);
        check("hold.flags", {28'b0, FlagsOut}, 32'hC);
        @(negedge Clock);
        Start = 1'b0;
        check("hold.done_ignored", {31'b0, Busy}, 32'd0);
        @(negedge Clock);
        check("hold.still_idle", {30'b0, Busy, Done}, 32'd0);

        // Reset in the third SHIFT cycle of a 10-step LSL.
        @(negedge Clock);
        FunSel = 5'b11011; A = 32'h0000FFFF; ShAmt = 5'd10; WF = 1'b1; Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        check("abort.busy_before", {31'b0, Busy}, 32'd1);
        Reset = 1'b1;
        #1;
        check("abort.out", ALUOut, 32'd0);
        check("abort.flags", {28'b0, FlagsOut}, 32'd0);
        check("abort.ctl", {30'b0, Busy, Done}, 32'd0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge Clock);
            if (Done) seen = 1'b1;
        end
        Reset = 1'b0;
        repeat (12) begin
            @(negedge Clock);
            if (Done || Busy) seen = 1'b1;
        end
        check("abort.no_done", {31'b0, seen}, 32'd0);

        // Half SUB 0-1 after the abort.
        run_vec('{5'b00110, 32'h00000000, 32'h00000001, 5'd0, 1'b1, 32'hFFFFFFFF, 4'b0010, 2},
                "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
